// File: rtl/device_bus_responder.sv
// Device-side bus responder: timer (TH/TL/TCON), LED, digit and systick
// registers mapped at 0x40000000, with combinational read-back.
module device_bus_responder #(
  parameter int LED_W  = 8,
  parameter int DIGI_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Device_Read,
  input  logic              Device_Write,
  input  logic [31:0]       MemBus_Address,
  input  logic [31:0]       MemBus_Write_Data,
  output logic [31:0]       Device_Read_Data,
  output logic [LED_W-1:0]  leds,
  output logic [DIGI_W-1:0] digits,
  output logic              irq
);

  localparam logic [29:0] BASE = 30'h1000_0000;

  logic [31:0]       r_th;
  logic [31:0]       r_tl;
  logic [2:0]        r_tcon;
  logic [LED_W-1:0]  r_led;
  logic [DIGI_W-1:0] r_digi;
  logic [31:0]       r_systick;

  logic [29:0] w_idx;
  logic        w_unused;
  logic        w_hit_th;
  logic        w_hit_tl;
  logic        w_hit_tcon;
  logic        w_hit_led;
  logic        w_hit_digi;
  logic        w_hit_st;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic        w_wr_led;
  logic        w_wr_digi;
  logic        w_run;
  logic        w_ovf;
  logic [31:0] w_led32;
  logic [31:0] w_digi32;
  logic [31:0] w_rdata;

  // Word decode only; the byte offset within a word is irrelevant.
  assign w_idx    = MemBus_Address[31:2];
  assign w_unused = ^MemBus_Address[1:0];

  assign w_hit_th   = (w_idx == BASE);
  assign w_hit_tl   = (w_idx == BASE + 30'd1);
  assign w_hit_tcon = (w_idx == BASE + 30'd2);
  assign w_hit_led  = (w_idx == BASE + 30'd3);
  assign w_hit_digi = (w_idx == BASE + 30'd4);
  assign w_hit_st   = (w_idx == BASE + 30'd5);

  assign w_wr_th   = Device_Write & w_hit_th;
  assign w_wr_tl   = Device_Write & w_hit_tl;
  assign w_wr_tcon = Device_Write & w_hit_tcon;
  assign w_wr_led  = Device_Write & w_hit_led;
  assign w_wr_digi = Device_Write & w_hit_digi;

  assign w_run = r_tcon[0];
  assign w_ovf = w_run & (&r_tl);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th <= '0;
    end else if (w_wr_th) begin
      r_th <= MemBus_Write_Data;
    end
  end

  // Reload uses the pre-edge TH, so a same-cycle TH write only
  // affects the following overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tl <= '0;
    end else if (w_wr_tl) begin
      r_tl <= MemBus_Write_Data;
    end else if (w_ovf) begin
      r_tl <= r_th;
    end else if (w_run) begin
      r_tl <= r_tl + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcon <= '0;
    end else if (w_wr_tcon) begin
      r_tcon <= MemBus_Write_Data[2:0];
    end else if (w_ovf && r_tcon[1]) begin
      r_tcon[2] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led <= '0;
    end else if (w_wr_led) begin
      r_led <= MemBus_Write_Data[LED_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digi <= '0;
    end else if (w_wr_digi) begin
      r_digi <= MemBus_Write_Data[DIGI_W-1:0];
    end
  end

  always_comb begin
    w_led32               = '0;
    w_led32[LED_W-1:0]    = r_led;
    w_digi32              = '0;
    w_digi32[DIGI_W-1:0]  = r_digi;
  end

  always_comb begin
    w_rdata = '0;
    if (Device_Read) begin
      unique case (1'b1)
        w_hit_th:   w_rdata = r_th;
        w_hit_tl:   w_rdata = r_tl;
        w_hit_tcon: w_rdata = {29'd0, r_tcon};
        w_hit_led:  w_rdata = w_led32;
        w_hit_digi: w_rdata = w_digi32;
        w_hit_st:   w_rdata = r_systick;
        default:    w_rdata = '0;
      endcase
    end
  end

  assign Device_Read_Data = w_rdata;
  assign leds             = r_led;
  assign digits           = r_digi;
  assign irq              = r_tcon[2];

endmodule

// File: tb/tb_device_bus_responder.sv
// Bench for device_bus_responder: reference register model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_device_bus_responder;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_ST   = 32'h4000_0014;

  logic        clk;
  logic        reset;
  logic        Device_Read;
  logic        Device_Write;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic [31:0] Device_Read_Data;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_th   = '0;
  logic [31:0] m_tl   = '0;
  logic [2:0]  m_tcon = '0;
  logic [7:0]  m_led  = '0;
  logic [11:0] m_digi = '0;
  logic [31:0] m_st   = '0;

  device_bus_responder dut (
    .clk               (clk),
    .reset             (reset),
    .Device_Read       (Device_Read),
    .Device_Write      (Device_Write),
    .MemBus_Address    (MemBus_Address),
    .MemBus_Write_Data (MemBus_Write_Data),
    .Device_Read_Data  (Device_Read_Data),
    .leds              (leds),
    .digits            (digits),
    .irq               (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
    logic [31:0] off;
    off = {a[31:2], 2'b00};
    if (!rd) return 32'h0;
    case (off)
      A_TH:    return m_th;
      A_TL:    return m_tl;
      A_TCON:  return {29'd0, m_tcon};
      A_LED:   return {24'd0, m_led};
      A_DIGI:  return {20'd0, m_digi};
      A_ST:    return m_st;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    m_th = '0; m_tl = '0; m_tcon = '0;
    m_led = '0; m_digi = '0; m_st = '0;
  endtask

  // One clock edge of the register file as described by the register map.
  task automatic model_edge();
    logic [31:0] off;
    logic [31:0] n_th, n_tl;
    logic [2:0]  n_tcon;
    logic        ovf;
    if (!reset) begin
      model_clear();
      return;
    end
    off = {MemBus_Address[31:2], 2'b00};
    ovf = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
    n_th = m_th;
    if (!m_tcon[0]) n_tl = m_tl;
    else if (ovf) n_tl = m_th;
    else n_tl = m_tl + 1;
    n_tcon = m_tcon;
    if (ovf && m_tcon[1]) n_tcon[2] = 1'b1;
    if (Device_Write) begin
      case (off)
        A_TH:   n_th = MemBus_Write_Data;
        A_TL:   n_tl = MemBus_Write_Data;
        A_TCON: n_tcon = MemBus_Write_Data[2:0];
        A_LED:  m_led = MemBus_Write_Data[7:0];
        A_DIGI: m_digi = MemBus_Write_Data[11:0];
        default: ;
      endcase
    end
    m_th = n_th; m_tl = n_tl; m_tcon = n_tcon;
    m_st = m_st + 1;
  endtask

  always @(negedge clk) begin
    chk("rdata", Device_Read_Data, m_read(Device_Read, MemBus_Address));
    chk("leds", {24'd0, leds}, {24'd0, m_led});
    chk("digits", {20'd0, digits}, {20'd0, m_digi});
    chk("irq", {31'd0, irq}, {31'd0, m_tcon[2]});
  end

  // Apply the previous inputs at the edge, drive new ones, stop at negedge.
  task automatic cyc(input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    model_edge();
    #1;
    Device_Read = rd;
    Device_Write = wr;
    MemBus_Address = a;
    MemBus_Write_Data = d;
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    cyc(1'b1, 1'b0, a, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    int k;
    reset = 1'b0;
    Device_Read = 1'b0;
    Device_Write = 1'b0;
    MemBus_Address = '0;
    MemBus_Write_Data = '0;
    #3;
    chk("rst_leds", {24'd0, leds}, 32'h0);
    chk("rst_digits", {20'd0, digits}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    cyc(1'b1, 1'b0, A_ST, 32'h0);
    chk("rst_read_st", Device_Read_Data, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;

    wr_reg(A_LED, 32'h0000_005A);
    wr_reg(A_DIGI, 32'h0000_0ABC);
    rd_reg(A_LED);
    chk("s1_leds", {24'd0, leds}, 32'h5A);
    chk("s1_rd_led", Device_Read_Data, 32'h0000_005A);
    rd_reg(A_DIGI + 32'd3);
    chk("s1_digits", {20'd0, digits}, 32'hABC);
    chk("s1_rd_digi", Device_Read_Data, 32'h0000_0ABC);

    wr_reg(A_TH, 32'hFFFF_FFFC);
    wr_reg(A_TL, 32'hFFFF_FFFE);
    wr_reg(A_TCON, 32'h3);
    rd_reg(A_TL);
    chk("s2_tl_start", Device_Read_Data, 32'hFFFF_FFFE);
    rd_reg(A_TL);
    chk("s2_tl_max", Device_Read_Data, 32'hFFFF_FFFF);
    chk("s2_irq_pre", {31'd0, irq}, 32'h0);
    rd_reg(A_TL);
    chk("s2_tl_reload", Device_Read_Data, 32'hFFFF_FFFC);
    chk("s2_irq", {31'd0, irq}, 32'h1);
    rd_reg(A_TL);
    chk("s2_tl_resume", Device_Read_Data, 32'hFFFF_FFFD);

    wr_reg(A_TCON, 32'h3);
    chk("s3_irq_held", {31'd0, irq}, 32'h1);
    wr_reg(A_TCON, 32'h1);
    chk("s3_irq_clr", {31'd0, irq}, 32'h0);
    rd_reg(A_TCON);
    chk("s4_tcon", Device_Read_Data, 32'h1);
    chk("s4_irq", {31'd0, irq}, 32'h0);
    rd_reg(A_TL);
    chk("s4_tl_count", Device_Read_Data, 32'hFFFF_FFFD);

    wr_reg(A_TL, 32'h100);
    rd_reg(A_TL);
    chk("s5_tl_wr", Device_Read_Data, 32'h100);
    rd_reg(A_TL);
    chk("s5_tl_inc", Device_Read_Data, 32'h101);

    wr_reg(A_TCON, 32'h0);
    wr_reg(A_TH, 32'h10);
    wr_reg(A_TL, 32'hFFFF_FFFE);
    wr_reg(A_TCON, 32'h1);
    rd_reg(A_TL);
    chk("th_tl_hold", Device_Read_Data, 32'hFFFF_FFFE);
    wr_reg(A_TH, 32'h20);
    rd_reg(A_TL);
    chk("th_old_reload", Device_Read_Data, 32'h10);
    chk("th_no_irq", {31'd0, irq}, 32'h0);
    rd_reg(A_TH);
    chk("th_new", Device_Read_Data, 32'h20);

    wr_reg(A_ST, 32'h0);
    rd_reg(32'h4000_0018);
    chk("s6_unmapped", Device_Read_Data, 32'h0);
    rd_reg(A_ST + 32'd1);
    chk("s6_st_live", {31'd0, Device_Read_Data != 32'h0}, 32'h1);

    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    reset = 1'b0;
    model_clear();
    Device_Read = 1'b1;
    MemBus_Address = A_TL;
    #1;
    chk("s7_leds", {24'd0, leds}, 32'h0);
    chk("s7_digits", {20'd0, digits}, 32'h0);
    chk("s7_irq", {31'd0, irq}, 32'h0);
    chk("s7_rd_tl", Device_Read_Data, 32'h0);
    cyc(1'b1, 1'b1, A_LED, 32'hFF);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    rd_reg(A_ST);
    chk("s7_st_restart", Device_Read_Data, 32'h1);

    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 7);
      a = 32'h4000_0000 + 32'(k * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom & 32'h3FFF_FFFF;
      d = $urandom;
      if (k == 1 && $urandom_range(0, 1) == 1)
        d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if (k == 2 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
      if (i == 350) begin
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("rnd_rst_leds", {24'd0, leds}, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
      end
    end
    cyc(1'b0, 1'b0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
